// File: rtl/store_rmw_unit.sv
// ============================================================================
// Module  : store_rmw_unit
// Brief   : Narrows SB/SH/SW stores onto a word-only memory port; sub-word
//           stores use read-modify-write, word stores a single write.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module store_rmw_unit #(
    parameter int BIG_ENDIAN  = 0,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_st_req,
    input  logic [1:0]  i_st_op,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_data,
    output logic        o_st_busy,
    output logic        o_st_done,
    output logic        o_st_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    localparam logic [1:0] c_OP_SB = 2'b00;
    localparam logic [1:0] c_OP_SH = 2'b01;
    localparam logic [1:0] c_OP_SW = 2'b10;
    localparam int         c_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_op;
    logic [1:0]           r_lane;
    logic [15:0]          r_data;
    logic [31:0]          r_wdata;
    logic [31:0]          r_maddr;
    logic                 r_err;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_bad;
    logic                 w_timeout;
    logic [4:0]           w_boff;
    logic [4:0]           w_hoff;
    logic [31:0]          w_merged;

    assign w_bad = (i_st_op == 2'b11)
                 || ((i_st_op == c_OP_SH) && i_st_addr[0])
                 || ((i_st_op == c_OP_SW) && (i_st_addr[1:0] != 2'b00));

    assign w_timeout = (ACK_TIMEOUT != 0) && !i_mem_ack && (r_cnt == c_TO_LAST);

    // Big-endian lane k sits at bit 24-8k, i.e. the inverted lane index.
    assign w_boff = (BIG_ENDIAN != 0) ? {~r_lane, 3'b000} : {r_lane, 3'b000};
    assign w_hoff = (BIG_ENDIAN != 0) ? {~r_lane[1], 4'b0000} : {r_lane[1], 4'b0000};

    always_comb begin
        w_merged = r_wdata;
        if (r_op == c_OP_SB) begin
            w_merged[w_boff +: 8] = r_data[7:0];
        end else if (r_op == c_OP_SH) begin
            w_merged[w_hoff +: 16] = r_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_st_req) begin
                    if (w_bad)                   w_next = S_DONE;
                    else if (i_st_op == c_OP_SW) w_next = S_WRITE;
                    else                         w_next = S_READ;
                end
            end
            S_READ: begin
                if (i_mem_ack)      w_next = S_MERGE;
                else if (w_timeout) w_next = S_DONE;
            end
            S_MERGE: w_next = S_WRITE;
            S_WRITE: begin
                if (i_mem_ack || w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'b00;
            r_lane  <= 2'b00;
            r_data  <= 16'h0000;
            r_wdata <= 32'h0000_0000;
            r_maddr <= 32'h0000_0000;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_st_req) begin
                        r_op    <= i_st_op;
                        r_lane  <= i_st_addr[1:0];
                        r_data  <= i_st_data[15:0];
                        r_wdata <= i_st_data;
                        r_maddr <= {i_st_addr[31:2], 2'b00};
                        r_err   <= w_bad;
                        r_cnt   <= '0;
                    end
                end
                S_READ: begin
                    if (i_mem_ack) begin
                        r_wdata <= i_mem_rdata;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                S_MERGE: begin
                    r_wdata <= w_merged;
                    r_cnt   <= '0;
                end
                S_WRITE: begin
                    if (!i_mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_st_busy   = (r_state != S_IDLE);
    assign o_st_done   = (r_state == S_DONE);
    assign o_st_err    = (r_state == S_DONE) && r_err;
    assign o_mem_req   = (r_state == S_READ) || (r_state == S_WRITE);
    assign o_mem_we    = (r_state == S_WRITE);
    assign o_mem_addr  = r_maddr;
    assign o_mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
// ============================================================================
// Module  : tb_store_rmw_unit
// Brief   : Directed bench; instance 0 is little-endian with ACK_TIMEOUT=4,
//           instance 1 big-endian with no timeout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_req;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  busy, done, err, mreq, mwe, mack, ack_en;
    logic [31:0] maddr [2];
    logic [31:0] mwdata[2];
    logic [31:0] rdata [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          req_cyc;
    int          writes[2], reads[2], reqcyc[2], done_cyc[2];
    logic [31:0] last_w[2], last_a[2];
    logic        done_err[2];
    logic        done_seen[2];

    always #5 clk = ~clk;

    assign mack = mreq & ack_en;

    store_rmw_unit #(.BIG_ENDIAN(0), .ACK_TIMEOUT(4)) u_le (
        .clk(clk), .rst_n(rst_n),
        .i_st_req(st_req), .i_st_op(st_op), .i_st_addr(st_addr), .i_st_data(st_data),
        .o_st_busy(busy[0]), .o_st_done(done[0]), .o_st_err(err[0]),
        .o_mem_req(mreq[0]), .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]),
        .o_mem_wdata(mwdata[0]), .i_mem_rdata(rdata[0]), .i_mem_ack(mack[0])
    );

    store_rmw_unit #(.BIG_ENDIAN(1), .ACK_TIMEOUT(0)) u_be (
        .clk(clk), .rst_n(rst_n),
        .i_st_req(st_req), .i_st_op(st_op), .i_st_addr(st_addr), .i_st_data(st_data),
        .o_st_busy(busy[1]), .o_st_done(done[1]), .o_st_err(err[1]),
        .o_mem_req(mreq[1]), .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]),
        .o_mem_wdata(mwdata[1]), .i_mem_rdata(rdata[1]), .i_mem_ack(mack[1])
    );

    // Bus monitor: cyc is the index of the cycle that just ended at this edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mreq[i]) reqcyc[i]++;
            if (mreq[i] && mack[i]) begin
                if (mwe[i]) begin
                    writes[i]++;
                    last_w[i] = mwdata[i];
                    last_a[i] = maddr[i];
                end else begin
                    reads[i]++;
                end
            end
            if (done[i]) begin
                done_seen[i] = 1'b1;
                done_err[i]  = err[i];
                done_cyc[i]  = cyc;
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            writes[i] = 0; reads[i] = 0; reqcyc[i] = 0; done_cyc[i] = -1;
            last_w[i] = 32'h0; last_a[i] = 32'h0; done_err[i] = 1'b0; done_seen[i] = 1'b0;
        end
        st_req  = 1'b1;
        st_op   = op;
        st_addr = addr;
        st_data = data;
        req_cyc = cyc;
        @(negedge clk);
        st_req  = 1'b0;
        for (int k = 0; k < 40 && !(done_seen[0] && done_seen[1]); k++) @(negedge clk);
        chk("done_wait", {31'd0, done_seen[0] && done_seen[1]}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        st_req  = 1'b0;
        st_op   = 2'b00;
        st_addr = 32'h0;
        st_data = 32'h0;
        ack_en  = 2'b11;
        rdata[0] = 32'h1122_3344;
        rdata[1] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {30'd0, mreq}, 32'd0);
        chk("rst_busy",    {30'd0, busy}, 32'd0);
        chk("rst_done",    {30'd0, done | err}, 32'd0);
        chk("rst_wdata",   mwdata[0] | mwdata[1] | maddr[0] | maddr[1], 32'd0);
        rst_n = 1'b1;

        store(2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("sw_le_wdata", last_w[0], 32'hDEAD_BEEF);
        chk("sw_be_wdata", last_w[1], 32'hDEAD_BEEF);
        chk("sw_addr",     last_a[0], 32'h0000_0100);
        chk("sw_writes",   writes[0], 32'd1);
        chk("sw_reads",    reads[0] + reads[1], 32'd0);
        chk("sw_err",      {31'd0, done_err[0] | done_err[1]}, 32'd0);
        chk("sw_latency",  done_cyc[0] - req_cyc, 32'd2);

        store(2'b00, 32'h0000_0103, 32'h0000_00AA);
        chk("sb103_le", last_w[0], 32'hAA22_3344);
        chk("sb103_be", last_w[1], 32'h1122_33AA);
        chk("sb103_rw", reads[0] * 16 + writes[0], 32'h11);
        chk("sb103_lat", done_cyc[1] - req_cyc, 32'd4);
        chk("sb103_err", {31'd0, done_err[0] | done_err[1]}, 32'd0);

        store(2'b01, 32'h0000_0202, 32'h0000_BEEF);
        chk("sh202_be",   last_w[1], 32'h1122_BEEF);
        chk("sh202_le",   last_w[0], 32'hBEEF_3344);
        chk("sh202_addr", last_a[1], 32'h0000_0200);

        store(2'b01, 32'h0000_0200, 32'hFFFF_1234);
        chk("sh200_le", last_w[0], 32'h1122_1234);
        chk("sh200_be", last_w[1], 32'h1234_3344);

        store(2'b00, 32'h0000_0100, 32'hFFFF_FF55);
        chk("sb100_le", last_w[0], 32'h1122_3355);
        chk("sb100_be", last_w[1], 32'h5522_3344);

        store(2'b01, 32'h0000_0201, 32'h0000_BEEF);
        chk("sh_mis_err", {30'd0, done_err[1], done_err[0]}, 32'd3);
        chk("sh_mis_req", reqcyc[0] + reqcyc[1], 32'd0);
        chk("sh_mis_lat", done_cyc[0] - req_cyc, 32'd1);

        store(2'b11, 32'h0000_0100, 32'h1234_5678);
        chk("ill_err", {30'd0, done_err[1], done_err[0]}, 32'd3);
        chk("ill_req", reqcyc[0] + reqcyc[1], 32'd0);

        store(2'b10, 32'h0000_0102, 32'h1234_5678);
        chk("sw_mis_err", {30'd0, done_err[1], done_err[0]}, 32'd3);
        chk("sw_mis_req", reqcyc[0] + reqcyc[1], 32'd0);

        ack_en = 2'b10;
        store(2'b00, 32'h0000_0100, 32'h0000_0077);
        chk("to_err",      {31'd0, done_err[0]}, 32'd1);
        chk("to_req_cyc",  reqcyc[0], 32'd4);
        chk("to_writes",   writes[0], 32'd0);
        chk("to_be_ok",    {31'd0, done_err[1]}, 32'd0);
        chk("to_be_wdata", last_w[1], 32'h7722_3344);

        ack_en = 2'b00;
        @(negedge clk);
        st_req = 1'b1; st_op = 2'b10; st_addr = 32'h0000_0300; st_data = 32'hCAFE_F00D;
        @(negedge clk);
        st_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", {30'd0, mreq & mwe}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop_req",  {30'd0, mreq}, 32'd0);
        chk("rst_drop_busy", {30'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 2'b11;
        store(2'b10, 32'h0000_0300, 32'hCAFE_F00D);
        chk("post_rst_le", last_w[0], 32'hCAFE_F00D);
        chk("post_rst_be", last_w[1], 32'hCAFE_F00D);
        chk("post_rst_wr", writes[0] + writes[1], 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
